// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the CPU/VGA memory bus arbiter: bus control codes and FSM states.
package bus_arbiter_pkg;

  localparam logic [1:0] CTRL_NONE  = 2'b00;
  localparam logic [1:0] CTRL_READ  = 2'b01;
  localparam logic [1:0] CTRL_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/bus_arbiter.sv
// Two-master (CPU, VGA) arbiter for a single shared memory bus with round-robin
// contention resolution and a mem_ready timeout that completes the access with bus_err.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter bit VGA_FIRST   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        vga_req,
  input  logic [15:0] vga_addr,
  output logic [15:0] vga_rdata,
  output logic        vga_ack,
  output logic [15:0] ADDRBUS,
  output logic [1:0]  CTRLBUS,
  output logic [15:0] DATAOUT,
  input  logic [15:0] DATAIN,
  input  logic        mem_ready,
  output logic        bus_err,
  output state_t      state_dbg
);

  // Handshake: a requester raises req with stable fields and holds them until its
  // one-cycle ack; the ack pulse (and rdata/bus_err alongside it) is registered.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  logic        grant_vga;
  logic        last_valid;
  logic        last_vga;
  logic        lat_wr;
  logic [15:0] wait_cnt;
  logic        pick_vga;
  logic        pick_wr;

  // Round robin: lone requester wins; on contention the one not served last wins.
  function automatic logic arb_pick_vga(input logic c_req, input logic v_req,
                                        input logic hist_valid, input logic hist_vga);
    logic sel;
    sel = 1'b0;
    if (v_req && !c_req)      sel = 1'b1;
    else if (c_req && !v_req) sel = 1'b0;
    else if (!hist_valid)     sel = VGA_FIRST;
    else                      sel = !hist_vga;
    return sel;
  endfunction

  assign pick_vga  = arb_pick_vga(cpu_req, vga_req, last_valid, last_vga);
  assign pick_wr   = !pick_vga && cpu_wr;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      grant_vga  <= 1'b0;
      last_valid <= 1'b0;
      last_vga   <= 1'b0;
      lat_wr     <= 1'b0;
      wait_cnt   <= 16'd0;
      ADDRBUS    <= 16'd0;
      CTRLBUS    <= CTRL_NONE;
      DATAOUT    <= 16'd0;
      cpu_ack    <= 1'b0;
      vga_ack    <= 1'b0;
      cpu_rdata  <= 16'd0;
      vga_rdata  <= 16'd0;
      bus_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cpu_ack   <= 1'b0;
          vga_ack   <= 1'b0;
          cpu_rdata <= 16'd0;
          vga_rdata <= 16'd0;
          bus_err   <= 1'b0;
          if (cpu_req || vga_req) begin
            grant_vga  <= pick_vga;
            last_valid <= 1'b1;
            last_vga   <= pick_vga;
            lat_wr     <= pick_wr;
            wait_cnt   <= 16'd0;
            ADDRBUS    <= pick_vga ? vga_addr : cpu_addr;
            CTRLBUS    <= pick_wr ? CTRL_WRITE : CTRL_READ;
            DATAOUT    <= pick_wr ? cpu_wdata : 16'd0;
            state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // mem_ready is checked first so it wins over a coincident timeout.
          if (mem_ready || (wait_cnt == TO_LAST)) begin
            cpu_ack   <= !grant_vga;
            vga_ack   <= grant_vga;
            cpu_rdata <= (!grant_vga && mem_ready && !lat_wr) ? DATAIN : 16'd0;
            vga_rdata <= (grant_vga && mem_ready) ? DATAIN : 16'd0;
            bus_err   <= !mem_ready;
            ADDRBUS   <= 16'd0;
            CTRLBUS   <= CTRL_NONE;
            DATAOUT   <= 16'd0;
            state     <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          cpu_ack   <= 1'b0;
          vga_ack   <= 1'b0;
          cpu_rdata <= 16'd0;
          vga_rdata <= 16'd0;
          bus_err   <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
